game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_pkg.sv | 54 +++++
 rtl/game_sequencer_seg7_decode.sv | 34 +++
 rtl/game_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg -- FSM states, playfield geometry, segment bit order
// and BCD helpers shared by the game_sequencer pong core.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_SCORED   = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    typedef logic signed [10:0] coord_t;

    localparam coord_t WALL_TOP = 11'sd38;
    localparam coord_t WALL_BOT = 11'sd512;
    localparam coord_t PLANE_L  = 11'sd148;
    localparam coord_t PLANE_R  = 11'sd780;
    localparam coord_t CENTRE_X = 11'sd464;
    localparam coord_t CENTRE_Y = 11'sd275;
    localparam coord_t EXT_LO   = 11'sd8;
    localparam coord_t EXT_HI   = 11'sd9;
    localparam coord_t PAD_HALF = 11'sd50;

    // Clamp positions sit one pixel inside each trigger threshold.
    localparam coord_t CLAMP_TOP = WALL_TOP + EXT_LO + 11'sd1;
    localparam coord_t CLAMP_BOT = WALL_BOT - EXT_HI - 11'sd1;
    localparam coord_t CLAMP_L   = PLANE_L + EXT_LO + 11'sd1;
    localparam coord_t CLAMP_R   = PLANE_R - EXT_HI - 11'sd1;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [6:0] bcd_val(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

endpackage

// File: rtl/game_sequencer_seg7_decode.sv
// seg7_decode -- BCD digit to active-high seven-segment pattern.
// Non-decimal codes blank the display.
module seg7_decode
    import game_sequencer_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Bit d of each mask lights that segment for digit d.
    localparam logic [9:0] M_A = 10'b11_1110_1101;
    localparam logic [9:0] M_B = 10'b11_1001_1111;
    localparam logic [9:0] M_C = 10'b11_1111_1011;
    localparam logic [9:0] M_D = 10'b11_0110_1101;
    localparam logic [9:0] M_E = 10'b01_0100_0101;
    localparam logic [9:0] M_F = 10'b11_0111_0001;
    localparam logic [9:0] M_G = 10'b11_0111_1100;

    logic [9:0] w_digit;

    assign w_digit = (i_bcd <= 4'd9) ? (10'd1 << i_bcd) : 10'd0;

    always_comb begin
        o_seg        = '0;
        o_seg[SEG_A] = |(w_digit & M_A);
        o_seg[SEG_B] = |(w_digit & M_B);
        o_seg[SEG_C] = |(w_digit & M_C);
        o_seg[SEG_D] = |(w_digit & M_D);
        o_seg[SEG_E] = |(w_digit & M_E);
        o_seg[SEG_F] = |(w_digit & M_F);
        o_seg[SEG_G] = |(w_digit & M_G);
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer -- pong serve/rally/score sequencer with BCD scoreboard.
// Define BALL_SPEEDUP_EN to speed the ball up on every paddle return.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int BASE_SPEED   = 2,
    parameter int MAX_SPEED    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] yposLeft,
    input  logic [9:0] yposRight,
    output logic [9:0] xcenter,
    output logic [9:0] ycenter,
    output logic [6:0] l_o,
    output logic [6:0] l_t,
    output logic [6:0] r_o,
    output logic [6:0] r_t,
    output logic [2:0] state,
    output logic       game_over
);

    localparam int SPD_TOP = (MAX_SPEED > BASE_SPEED) ? MAX_SPEED : BASE_SPEED;
    localparam int SPD_W   = $clog2(SPD_TOP + 1);
    localparam int CNT_W   = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_vx_pos;
    logic             r_vy_pos;
    logic [SPD_W-1:0] r_speed;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_l_score;
    logic [7:0]       r_r_score;
    logic             r_left_scored;
    logic             r_conc_right;

    coord_t w_x, w_y, w_spd, w_nx, w_ny, w_dl, w_dr;
    coord_t w_x_mv, w_y_mv;
    logic   w_vx_mv, w_vy_mv;
    logic   w_top, w_bot;
    logic   w_zone_l, w_zone_r, w_in_l, w_in_r;
    logic   w_hit, w_miss;
    logic   w_serve_done, w_enter_serve, w_win;
    logic [7:0] w_new_score;

    // Motion and collision for one frame, all in 11-bit signed space.
    always_comb begin
        w_x      = coord_t'({1'b0, r_x});
        w_y      = coord_t'({1'b0, r_y});
        w_spd    = coord_t'(r_speed);
        w_nx     = r_vx_pos ? w_x + w_spd : w_x - w_spd;
        w_ny     = r_vy_pos ? w_y + 11'sd1 : w_y - 11'sd1;
        w_top    = (w_ny - EXT_LO) <= WALL_TOP;
        w_bot    = (w_ny + EXT_HI) >= WALL_BOT;
        w_dl     = w_y - coord_t'({1'b0, yposLeft});
        w_dr     = w_y - coord_t'({1'b0, yposRight});
        w_in_l   = (w_dl >= -PAD_HALF) && (w_dl <= PAD_HALF);
        w_in_r   = (w_dr >= -PAD_HALF) && (w_dr <= PAD_HALF);
        w_zone_l = !r_vx_pos && ((w_nx - EXT_LO) <= PLANE_L);
        w_zone_r = r_vx_pos && ((w_nx + EXT_HI) >= PLANE_R);
        w_hit    = (w_zone_l && w_in_l) || (w_zone_r && w_in_r);
        w_miss   = (w_zone_l && !w_in_l) || (w_zone_r && !w_in_r);

        w_vy_mv = r_vy_pos;
        w_y_mv  = w_ny;
        if (w_top) begin
            w_vy_mv = 1'b1;
            w_y_mv  = CLAMP_TOP;
        end else if (w_bot) begin
            w_vy_mv = 1'b0;
            w_y_mv  = CLAMP_BOT;
        end

        w_vx_mv = r_vx_pos;
        w_x_mv  = w_nx;
        if (w_zone_l && w_in_l) begin
            w_vx_mv = 1'b1;
            w_x_mv  = CLAMP_L;
        end else if (w_zone_r && w_in_r) begin
            w_vx_mv = 1'b0;
            w_x_mv  = CLAMP_R;
        end
    end

    assign w_serve_done = frame_tick && (r_cnt == CNT_W'(SERVE_FRAMES - 1));
    assign w_new_score  = bcd_inc(r_left_scored ? r_l_score : r_r_score);
    assign w_win        = bcd_val(w_new_score) == 7'(WIN_SCORE);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_next = ST_SERVE;
            ST_SERVE:    if (w_serve_done) w_next = ST_PLAY;
            ST_PLAY:     if (frame_tick && w_miss) w_next = ST_SCORED;
            ST_SCORED:   w_next = w_win ? ST_GAMEOVER : ST_SERVE;
            ST_GAMEOVER: if (start) w_next = ST_SERVE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        state     = r_state;
        game_over = (r_state == ST_GAMEOVER);
    end

    assign w_enter_serve = (w_next == ST_SERVE) && (r_state != ST_SERVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= 10'(CENTRE_X);
            r_y           <= 10'(CENTRE_Y);
            r_vx_pos      <= 1'b1;
            r_vy_pos      <= 1'b1;
            r_cnt         <= '0;
            r_l_score     <= '0;
            r_r_score     <= '0;
            r_left_scored <= 1'b0;
            r_conc_right  <= 1'b1;
        end else begin
            if (w_enter_serve)
                r_cnt <= '0;
            else if (r_state == ST_SERVE && frame_tick)
                r_cnt <= r_cnt + CNT_W'(1);

            if (r_state == ST_PLAY) begin
                if (frame_tick) begin
                    if (w_miss) begin
                        r_x           <= 10'(CENTRE_X);
                        r_y           <= 10'(CENTRE_Y);
                        r_left_scored <= w_zone_r;
                        r_conc_right  <= w_zone_r;
                    end else begin
                        r_x      <= 10'(w_x_mv);
                        r_y      <= 10'(w_y_mv);
                        r_vx_pos <= w_vx_mv;
                        r_vy_pos <= w_vy_mv;
                    end
                end
            end else begin
                r_x <= 10'(CENTRE_X);
                r_y <= 10'(CENTRE_Y);
                // Launch toward whoever conceded the last point.
                if (r_state == ST_SERVE && w_serve_done) begin
                    r_vx_pos <= r_conc_right;
                    r_vy_pos <= 1'b1;
                end
            end

            if (r_state == ST_SCORED) begin
                if (r_left_scored)
                    r_l_score <= w_new_score;
                else
                    r_r_score <= w_new_score;
            end else if (r_state == ST_GAMEOVER && start) begin
                r_l_score    <= '0;
                r_r_score    <= '0;
                r_conc_right <= 1'b1;
            end
        end
    end

`ifdef BALL_SPEEDUP_EN
    always_ff @(posedge clk) begin
        if (rst || w_enter_serve)
            r_speed <= SPD_W'(BASE_SPEED);
        else if (r_state == ST_PLAY && frame_tick && w_hit
                 && r_speed < SPD_W'(MAX_SPEED))
            r_speed <= r_speed + SPD_W'(1);
    end
`else
    logic w_unused_hit;
    assign w_unused_hit = w_hit;

    always_ff @(posedge clk) begin
        r_speed <= SPD_W'(BASE_SPEED);
    end
`endif

    assign xcenter = r_x;
    assign ycenter = r_y;

    seg7_decode u_seg_lo (.i_bcd(r_l_score[3:0]), .o_seg(l_o));
    seg7_decode u_seg_lt (.i_bcd(r_l_score[7:4]), .o_seg(l_t));
    seg7_decode u_seg_ro (.i_bcd(r_r_score[3:0]), .o_seg(r_o));
    seg7_decode u_seg_rt (.i_bcd(r_r_score[7:4]), .o_seg(r_t));

endmodule
